// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first, one bit per clock.
// A single full-adder cell (two half adders plus an OR) is reused each
// RUN cycle. The IDLE -> RUN -> DONE FSM owns sequencing; Sum/Cout only
// change on the edge that enters DONE, so partial results are never visible.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the Ovf output
// (two's-complement overflow of the completed addition).

module sa_half_adder (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;
endmodule

module sa_full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   logic s0, c0, c1;

   sa_half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s0),  .c_o(c0));
   sa_half_adder u_ha1 (.a_i(s0),  .b_i(c_i), .s_o(s_o), .c_o(c1));

   assign c_o = c0 | c1;
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic            Ovf
`endif
);

   localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
   logic [WIDTH-1:0] acc_shift;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q;
   logic             fa_s, fa_c;
   logic             accept, last_bit;

   assign accept   = (state_q == S_IDLE) && start;
   assign last_bit = (cnt_q == LAST);

   sa_full_adder u_fa (
      .a_i (a_q[0]),
      .b_i (b_q[0]),
      .c_i (carry_q),
      .s_o (fa_s),
      .c_o (fa_c)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB
   generate
      if (WIDTH == 1) begin : g_acc1
         assign acc_shift = fa_s;
      end else begin : g_accn
         assign acc_shift = {fa_s, acc_q[WIDTH-1:1]};
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; the spare encoding falls back to IDLE
   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:  state_d = start ? S_RUN : S_IDLE;
         S_RUN:   state_d = last_bit ? S_DONE : S_RUN;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs decoded from the current state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_RUN:   busy = 1'b1;
         S_DONE:  begin busy = 1'b1; done = 1'b1; end
         default: begin busy = 1'b0; done = 1'b0; end
      endcase
   end

   // Operand capture, serial shift/carry datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else if (accept) begin
         a_q     <= A;
         b_q     <= B;
         carry_q <= Cin;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else if (state_q == S_RUN) begin
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         carry_q <= fa_c;
         acc_q   <= acc_shift;
         cnt_q   <= cnt_q + CW'(1);
         if (last_bit) begin
            sum_q  <= acc_shift;
            cout_q <= fa_c;
         end
      end
   end

   assign Sum  = sum_q;
   assign Cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q;

   // Overflow: carry into the MSB (carry_q on the last bit) vs carry out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          ovf_q <= 1'b0;
      else if (state_q == S_RUN && last_bit) ovf_q <= carry_q ^ fa_c;
   end

   assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized + directed bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1).
module tb_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic       start, Cin, busy, done, Cout;
   logic [7:0] A, B, Sum;
   // WIDTH=1 instance
   logic       s1_start, s1_Cin, s1_busy, s1_done, s1_Cout;
   logic [0:0] s1_A, s1_B, s1_Sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic       Ovf, s1_Ovf;
`endif

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
      .busy(busy), .done(done), .Sum(Sum), .Cout(Cout)
`ifdef SERIAL_ADDER_OVF_EN
      , .Ovf(Ovf)
`endif
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(s1_start), .A(s1_A), .B(s1_B), .Cin(s1_Cin),
      .busy(s1_busy), .done(s1_done), .Sum(s1_Sum), .Cout(s1_Cout)
`ifdef SERIAL_ADDER_OVF_EN
      , .Ovf(s1_Ovf)
`endif
   );

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] last_sum;
   logic       last_cout;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer addition
   function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {8'd0, c};
   endfunction

   // One WIDTH=8 operation; scr drives operands to zero mid-RUN
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit scr);
      logic [8:0] r;
      int e, bcnt;
      bit seen, hold_ok;
      r = ref_add(a, b, c);
      e = 0; bcnt = 0; seen = 0; hold_ok = 1;
      @(negedge clk);
      A = a; B = b; Cin = c; start = 1'b1;
      @(posedge clk);                      // accepting edge
      while (e < 40) begin
         @(negedge clk);
         if (e == 0) start = 1'b0;
         if (busy) bcnt++;
         if (done) begin seen = 1; break; end
         if (Sum !== last_sum || Cout !== last_cout) hold_ok = 0;
         if (scr && e == 3) begin A = 8'h00; B = 8'h00; Cin = 1'b0; end
         e++;
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("latency", 32'(e), 32'd8);
      chk("busy_cycles", 32'(bcnt), 32'd9);
      chk("no_partial", 32'(hold_ok), 32'd1);
      chk("sum", 32'(Sum), 32'(r[7:0]));
      chk("cout", 32'(Cout), 32'(r[8]));
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", 32'(Ovf), 32'((a[7] == b[7]) && (r[7] != a[7])));
`endif
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      last_sum = r[7:0];
      last_cout = r[8];
   endtask

   // One WIDTH=1 operation
   task automatic op1(input logic a, input logic b, input logic c);
      int tot, e;
      bit seen;
      tot = int'(a) + int'(b) + int'(c);
      e = 0; seen = 0;
      @(negedge clk);
      s1_A = a; s1_B = b; s1_Cin = c; s1_start = 1'b1;
      @(posedge clk);
      while (e < 10) begin
         @(negedge clk);
         if (e == 0) s1_start = 1'b0;
         if (s1_done) begin seen = 1; break; end
         e++;
      end
      chk("w1_done_seen", 32'(seen), 32'd1);
      chk("w1_latency", 32'(e), 32'd1);
      chk("w1_sum", 32'(s1_Sum), 32'(tot & 1));
      chk("w1_cout", 32'(s1_Cout), 32'(tot >> 1));
`ifdef SERIAL_ADDER_OVF_EN
      chk("w1_ovf", 32'(s1_Ovf), 32'((a == b) && ((tot & 1) != int'(a))));
`endif
      @(negedge clk);
      chk("w1_idle_busy", 32'(s1_busy), 32'd0);
   endtask

   // start held high: accept every 10th edge, one-cycle busy gap
   task automatic held_start();
      logic [8:0] r;
      int d[$];
      int lows;
      bit sum_ok;
      logic [7:0] a, b;
      a = 8'($urandom); b = 8'($urandom);
      r = ref_add(a, b, 1'b0);
      lows = 0; sum_ok = 1;
      @(negedge clk);
      A = a; B = b; Cin = 1'b0; start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done) begin
            d.push_back(k);
            if (Sum !== r[7:0] || Cout !== r[8]) sum_ok = 0;
         end
         if (!busy && d.size() >= 1 && d.size() < 3) lows++;
         if (k == 29) start = 1'b0;
      end
      chk("held_ndone", 32'(d.size()), 32'd3);
      if (d.size() == 3) begin
         chk("held_first", 32'(d[0]), 32'd8);
         chk("held_gap1", 32'(d[1] - d[0]), 32'd10);
         chk("held_gap2", 32'(d[2] - d[1]), 32'd10);
      end
      chk("held_busy_low", 32'(lows), 32'd2);
      chk("held_sum", 32'(sum_ok), 32'd1);
      last_sum = r[7:0];
      last_cout = r[8];
   endtask

   // Reset pulsed in the middle of RUN
   task automatic reset_mid_run();
      bit no_done;
      no_done = 1;
      @(negedge clk);
      A = 8'h12; B = 8'h34; Cin = 1'b1; start = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(Sum), 32'd0);
      chk("rst_cout", 32'(Cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done || busy) no_done = 0;
      end
      chk("rst_no_done", 32'(no_done), 32'd1);
      last_sum = 8'h00;
      last_cout = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
      s1_start = 1'b0; s1_A = '0; s1_B = '0; s1_Cin = 1'b0;
      last_sum = 8'h00; last_cout = 1'b0;
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_sum", 32'(Sum), 32'd0);
      chk("reset_cout", 32'(Cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("reset_ovf", 32'(Ovf), 32'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      op8(8'hFF, 8'h01, 1'b0, 0);
      op8(8'h5A, 8'h33, 1'b1, 1);
      op8(8'h7F, 8'h01, 1'b0, 0);
      op8(8'hFF, 8'hFF, 1'b1, 0);
      op8(8'h00, 8'h00, 1'b0, 0);
      op8(8'h80, 8'h80, 1'b0, 1);
      for (int i = 0; i < 16; i++)
         op8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));

      held_start();
      @(negedge clk);
      @(negedge clk);
      op8(8'hC3, 8'h3C, 1'b1, 0);

      reset_mid_run();
      op8(8'h10, 8'h20, 1'b0, 0);

      for (int i = 0; i < 8; i++)
         op1(1'(i >> 2), 1'(i >> 1), 1'(i));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
